ad_avg_pack: RTL and testbench
==============================

AD_AVG_PACK -- requirements
Module: ad_avg_pack

Interface
REQ-001 The block SHALL have parameter AVG_LOG2, default 4, meaning log2 of the number of frames averaged per output set (legal 0..6).
REQ-002 The block SHALL have port clk, input, 1 bit: system clock, the same clock domain as the ADC interface.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port ena, input, 1 bit: capture enable; while low, val_dat is ignored.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear of all state.
REQ-006 The block SHALL have port val_dat, input, 1 bit: one-cycle strobe marking a complete 8-channel frame.
REQ-007 The block SHALL have ports ad_dat0..ad_dat7, input, 14 bits each: unsigned samples, valid while val_dat=1.
REQ-008 The block SHALL have port out_valid, output, 1 bit: stream word valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-010 The block SHALL have port out_dat, output, 16 bits: stream word.
REQ-011 The block SHALL have port ovr, output, 1 bit: sticky overrun flag.

Function
REQ-012 Each val_dat=1 with ena=1 SHALL add ad_datN into acc[N] (14+AVG_LOG2 bits, no overflow possible) and increment frame counter cnt_frm (modulo 2^AVG_LOG2).
REQ-013 On the accepted frame where cnt_frm = 2^AVG_LOG2-1, the block SHALL compute avg[N] = (acc[N]+ad_datN) >> AVG_LOG2 (truncation, 14 bits), zero acc[] and cnt_frm, and produce a "set ready" event.
REQ-014 The output FSM SHALL have states IDLE, HDR, DATA, and a 3-bit channel index ch.
REQ-015 On a set-ready event, if the buffer is free, the FSM SHALL load the 8 averages into the output buffer and enter HDR at the same edge, so that out_valid rises 1 cycle after the final val_dat.
REQ-016 The buffer SHALL be free when state = IDLE, or when state = DATA, ch = 7, and out_ready = 1 in that cycle; in the latter case the next set SHALL be loaded and HDR entered with no bubble.
REQ-017 In HDR, out_dat SHALL be {2'b11, seq[13:0]}; a handshake (out_valid & out_ready) SHALL move the FSM to DATA with ch = 0.
REQ-018 In DATA, out_dat SHALL be {2'b00, avg[ch]}; each handshake SHALL increment ch, and the handshake at ch = 7 SHALL return the FSM to IDLE (or HDR per REQ-016) and increment seq (14-bit, wraps 16383->0).
REQ-019 out_valid SHALL be 1 exactly in HDR and DATA; out_dat SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 A set-ready event while the buffer is not free SHALL discard that set, leave the buffer and FSM untouched, and set ovr=1; seq SHALL NOT advance for the dropped set.
REQ-021 ovr SHALL remain set until clr or reset.
REQ-022 clr=1 SHALL zero acc[], cnt_frm, ch, seq, and ovr, force IDLE, and take priority over a coincident val_dat and handshake.
REQ-023 A frame arriving while ena=0 SHALL have no effect; partial accumulation SHALL be retained across ena low periods.

Reset
REQ-024 While rst=0, the block SHALL hold out_valid=0, out_dat=0, ovr=0, state=IDLE, and acc[], cnt_frm, ch, seq, and the buffer all at 0.
REQ-025 A reset asserted mid-set or mid-stream SHALL abandon that data with no partial output after release.

Structure
REQ-026 A shared package ad_pkg SHALL hold CH_NUM=8, AD_W=14, OUT_W=16, HDR_TAG=2'b11, DAT_TAG=2'b00, and the FSM state encoding.
REQ-027 The per-channel accumulate/divide logic SHALL be a sub-module ad_ch_acc (inputs add_en, clr_acc, last, sample; output avg), instantiated 8 times.
REQ-028 The FSM, seq counter, buffer, and ovr logic SHALL reside in ad_avg_pack.

Verification
REQ-029 With AVG_LOG2=2, four frames of ch0=100/200/300/400 and other channels 8191, out_ready=1 -> words C000, 00FA, then seven words 1FFF; out_valid rises 1 cycle after the 4th val_dat.
REQ-030 With AVG_LOG2=2, four frames of ch3 = 1,1,1,2 -> avg 1 (truncation); four frames of 3FFF -> 3FFF with no overflow.
REQ-031 With out_ready=0 held, a second set completing during HDR -> ovr=1, the first set streams intact with seq=0, and the next emitted header is C001.
REQ-032 With out_ready=1, a set completing in the same cycle as the ch7 handshake -> the next cycle shows header C001, out_valid stays continuously 1, and ovr=0.
REQ-033 Random out_ready backpressure -> out_dat is stable while stalled; clr mid-DATA -> out_valid=0 next cycle, and the next header is C000.
REQ-034 ena=0 for frames 2-3 of 6 -> the output equals the average of frames 1, 4, 5, 6; rst pulse mid-stream -> all outputs are 0.

Source files
------------

// File: rtl/ad_pkg.sv
// Shared constants and FSM encoding for the 8-channel ADC averaging packer.
package ad_pkg;

   localparam int CH_NUM = 8;
   localparam int CH_W   = 3;
   localparam int AD_W   = 14;
   localparam int OUT_W  = 16;
   localparam int SEQ_W  = 14;

   localparam logic [1:0] HDR_TAG = 2'b11;
   localparam logic [1:0] DAT_TAG = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } st_t;

endpackage

// File: rtl/ad_ch_acc.sv
// One channel of frame accumulation; avg is combinational so the owner can
// capture it on the same edge that delivers the final frame of a set.
module ad_ch_acc
   import ad_pkg::*;
#(
   parameter int AVG_LOG2 = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            add_en,
   input  logic            clr_acc,
   input  logic            last,
   input  logic [AD_W-1:0] sample,
   output logic [AD_W-1:0] avg
);

   localparam int ACC_W = AD_W + AVG_LOG2;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] sum;

   // Width leaves room for 2^AVG_LOG2 full-scale samples, so the add never wraps.
   assign sum = acc_q + ACC_W'(sample);
   assign avg = AD_W'(sum >> AVG_LOG2);

   always_comb begin
      acc_d = acc_q;
      if (clr_acc) begin
         acc_d = '0;
      end else if (add_en) begin
         acc_d = last ? '0 : sum;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/ad_avg_pack.sv
// Averages 2^AVG_LOG2 ADC frames per channel and streams each set as a
// header word followed by eight data words over a valid/ready interface.
//
// state   | meaning
// IDLE    | no set buffered, out_valid low
// HDR     | presenting header {11, seq}
// DATA    | presenting {00, avg[ch]}, ch = 0..7
module ad_avg_pack
   import ad_pkg::*;
#(
   parameter int AVG_LOG2 = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             clr,
   input  logic             val_dat,
   input  logic [AD_W-1:0]  ad_dat0,
   input  logic [AD_W-1:0]  ad_dat1,
   input  logic [AD_W-1:0]  ad_dat2,
   input  logic [AD_W-1:0]  ad_dat3,
   input  logic [AD_W-1:0]  ad_dat4,
   input  logic [AD_W-1:0]  ad_dat5,
   input  logic [AD_W-1:0]  ad_dat6,
   input  logic [AD_W-1:0]  ad_dat7,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_dat,
   output logic             ovr
);

   localparam int              CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CH_NUM - 1);

   st_t              st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic             ovr_q, ovr_d;
   logic [AD_W-1:0]  buf_q [CH_NUM];
   logic [AD_W-1:0]  buf_d [CH_NUM];

   logic [AD_W-1:0]  sample [CH_NUM];
   logic [AD_W-1:0]  avg    [CH_NUM];

   logic frm_acc;
   logic last_frm;
   logic set_rdy;
   logic hs_last;
   logic buf_free;
   logic load;

   assign sample[0] = ad_dat0;
   assign sample[1] = ad_dat1;
   assign sample[2] = ad_dat2;
   assign sample[3] = ad_dat3;
   assign sample[4] = ad_dat4;
   assign sample[5] = ad_dat5;
   assign sample[6] = ad_dat6;
   assign sample[7] = ad_dat7;

   assign frm_acc  = ena & val_dat & ~clr;
   assign last_frm = (cnt_q == CNT_MAX);
   assign set_rdy  = frm_acc & last_frm;
   assign hs_last  = (st_q == ST_DATA) & (ch_q == CH_LAST) & out_ready;
   // Freeing on the final handshake lets a new set follow with no idle cycle.
   assign buf_free = (st_q == ST_IDLE) | hs_last;
   assign load     = set_rdy & buf_free;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      ad_ch_acc #(
         .AVG_LOG2 (AVG_LOG2)
      ) u_ch_acc (
         .clk     (clk),
         .rst     (rst),
         .add_en  (frm_acc),
         .clr_acc (clr),
         .last    (last_frm),
         .sample  (sample[g]),
         .avg     (avg[g])
      );
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (frm_acc) begin
         cnt_d = last_frm ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q <= ST_IDLE;
      end else begin
         st_q <= st_d;
      end
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_IDLE: if (load)      st_d = ST_HDR;
         ST_HDR:  if (out_ready) st_d = ST_DATA;
         ST_DATA: if (hs_last)   st_d = load ? ST_HDR : ST_IDLE;
         default:                st_d = ST_IDLE;
      endcase
      if (clr) begin
         st_d = ST_IDLE;
      end
   end

   always_comb begin
      out_valid = 1'b0;
      out_dat   = '0;
      case (st_q)
         ST_HDR: begin
            out_valid = 1'b1;
            out_dat   = {HDR_TAG, seq_q};
         end
         ST_DATA: begin
            out_valid = 1'b1;
            out_dat   = {DAT_TAG, buf_q[ch_q]};
         end
         default: begin
            out_valid = 1'b0;
            out_dat   = '0;
         end
      endcase
   end

   assign ovr = ovr_q;

   // A set finishing while the buffer is busy is dropped, so seq only counts emitted sets.
   always_comb begin
      ch_d  = ch_q;
      seq_d = seq_q;
      ovr_d = ovr_q;
      buf_d = buf_q;
      if (clr) begin
         ch_d  = '0;
         seq_d = '0;
         ovr_d = 1'b0;
         buf_d = '{default: '0};
      end else begin
         if (load) begin
            buf_d = avg;
         end
         if (set_rdy && !buf_free) begin
            ovr_d = 1'b1;
         end
         if ((st_q == ST_HDR) && out_ready) begin
            ch_d = '0;
         end
         if ((st_q == ST_DATA) && out_ready) begin
            ch_d = ch_q + 1'b1;
         end
         if (hs_last) begin
            seq_d = seq_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         ch_q  <= '0;
         seq_q <= '0;
         ovr_q <= 1'b0;
         buf_q <= '{default: '0};
      end else begin
         cnt_q <= cnt_d;
         ch_q  <= ch_d;
         seq_q <= seq_d;
         ovr_q <= ovr_d;
         buf_q <= buf_d;
      end
   end

endmodule

// File: tb/tb_ad_avg_pack.sv
// Directed self-checking bench for ad_avg_pack with AVG_LOG2 = 2 (4-frame sets).
module tb_ad_avg_pack;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic        clr;
   logic        val_dat;
   logic [13:0] ad_dat0, ad_dat1, ad_dat2, ad_dat3;
   logic [13:0] ad_dat4, ad_dat5, ad_dat6, ad_dat7;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_dat;
   logic        ovr;

   int total = 0;
   int bad   = 0;

   logic [13:0] fr    [8];
   logic [15:0] exp_w [9];

   always #5 clk = ~clk;

   ad_avg_pack #(.AVG_LOG2(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .clr       (clr),
      .val_dat   (val_dat),
      .ad_dat0   (ad_dat0),
      .ad_dat1   (ad_dat1),
      .ad_dat2   (ad_dat2),
      .ad_dat3   (ad_dat3),
      .ad_dat4   (ad_dat4),
      .ad_dat5   (ad_dat5),
      .ad_dat6   (ad_dat6),
      .ad_dat7   (ad_dat7),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dat   (out_dat),
      .ovr       (ovr)
   );

   task automatic set_fr(input logic [13:0] c0, input logic [13:0] rest);
      fr[0] = c0;
      for (int i = 1; i < 8; i++) fr[i] = rest;
   endtask

   task automatic drive_fr();
      ad_dat0 = fr[0]; ad_dat1 = fr[1]; ad_dat2 = fr[2]; ad_dat3 = fr[3];
      ad_dat4 = fr[4]; ad_dat5 = fr[5]; ad_dat6 = fr[6]; ad_dat7 = fr[7];
   endtask

   task automatic send_frame(input logic en);
      drive_fr();
      ena     = en;
      val_dat = 1'b1;
      @(negedge clk);
      val_dat = 1'b0;
      ena     = 1'b1;
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; ena = 1'b1; clr = 1'b0; val_dat = 1'b0; out_ready = 1'b0;
      set_fr(14'd0, 14'd0);
      drive_fr();
      repeat (2) @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || out_dat !== 16'h0000 || ovr !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold: got v=%b d=%h ovr=%b, want v=0 d=0000 ovr=0", out_valid, out_dat, ovr);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || ovr !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got v=%b ovr=%b, want 0 0", out_valid, ovr);
      end
   endtask

   task automatic test_basic();
      clr_pulse();
      out_ready = 1'b1;
      for (int f = 0; f < 4; f++) begin
         set_fr(14'(100 * (f + 1)), 14'd8191);
         send_frame(1'b1);
         if (f < 3) begin
            total++;
            if (out_valid !== 1'b0) begin
               bad++;
               $display("FAIL basic_early_valid f%0d: got v=%b want 0", f, out_valid);
            end
         end
      end
      exp_w[0] = 16'hC000;
      exp_w[1] = 16'h00FA;
      for (int i = 2; i < 9; i++) exp_w[i] = 16'h1FFF;
      for (int k = 0; k < 9; k++) begin
         total++;
         if (out_valid !== 1'b1 || out_dat !== exp_w[k]) begin
            bad++;
            $display("FAIL basic_w%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_dat, exp_w[k]);
         end
         @(negedge clk);
      end
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_idle: got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_trunc();
      logic [13:0] c3 [4];
      c3[0] = 14'd1; c3[1] = 14'd1; c3[2] = 14'd1; c3[3] = 14'd2;
      clr_pulse();
      out_ready = 1'b1;
      for (int f = 0; f < 4; f++) begin
         set_fr(14'h3FFF, 14'h3FFF);
         fr[3] = c3[f];
         send_frame(1'b1);
      end
      exp_w[0] = 16'hC000;
      for (int i = 1; i < 9; i++) exp_w[i] = 16'h3FFF;
      exp_w[4] = 16'h0001;
      for (int k = 0; k < 9; k++) begin
         total++;
         if (out_valid !== 1'b1 || out_dat !== exp_w[k]) begin
            bad++;
            $display("FAIL trunc_w%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_dat, exp_w[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_overrun();
      clr_pulse();
      out_ready = 1'b0;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 8; i++) fr[i] = 14'(10 * (i + 1));
         send_frame(1'b1);
      end
      total++;
      if (out_valid !== 1'b1 || out_dat !== 16'hC000 || ovr !== 1'b0) begin
         bad++;
         $display("FAIL ovr_first_hdr: got v=%b d=%h ovr=%b want 1 C000 0", out_valid, out_dat, ovr);
      end
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 8; i++) fr[i] = 14'(1000 + i);
         send_frame(1'b1);
      end
      total++;
      if (ovr !== 1'b1 || out_dat !== 16'hC000) begin
         bad++;
         $display("FAIL ovr_flag: got ovr=%b d=%h want ovr=1 d=C000", ovr, out_dat);
      end
      exp_w[0] = 16'hC000;
      for (int i = 0; i < 8; i++) exp_w[i + 1] = 16'(10 * (i + 1));
      out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         total++;
         if (out_valid !== 1'b1 || out_dat !== exp_w[k]) begin
            bad++;
            $display("FAIL ovr_w%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_dat, exp_w[k]);
         end
         @(negedge clk);
      end
      total++;
      if (out_valid !== 1'b0 || ovr !== 1'b1) begin
         bad++;
         $display("FAIL ovr_after: got v=%b ovr=%b want v=0 ovr=1", out_valid, ovr);
      end
      for (int f = 0; f < 4; f++) begin
         set_fr(14'd7, 14'd7);
         send_frame(1'b1);
      end
      total++;
      if (out_valid !== 1'b1 || out_dat !== 16'hC001) begin
         bad++;
         $display("FAIL ovr_next_hdr: got v=%b d=%h want v=1 d=C001", out_valid, out_dat);
      end
   endtask

   task automatic test_back_to_back();
      clr_pulse();
      out_ready = 1'b1;
      for (int f = 0; f < 4; f++) begin
         set_fr(14'd20, 14'd20);
         send_frame(1'b1);
      end
      exp_w[0] = 16'hC000;
      for (int i = 1; i < 9; i++) exp_w[i] = 16'h0014;
      for (int k = 0; k < 9; k++) begin
         total++;
         if (out_valid !== 1'b1 || out_dat !== exp_w[k]) begin
            bad++;
            $display("FAIL b2b_a_w%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_dat, exp_w[k]);
         end
         set_fr(14'd50, 14'd50);
         drive_fr();
         ena     = 1'b1;
         val_dat = (k >= 5);
         @(negedge clk);
      end
      val_dat = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_dat !== 16'hC001 || ovr !== 1'b0) begin
         bad++;
         $display("FAIL b2b_hdr: got v=%b d=%h ovr=%b want 1 C001 0", out_valid, out_dat, ovr);
      end
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         total++;
         if (out_valid !== 1'b1 || out_dat !== 16'h0032) begin
            bad++;
            $display("FAIL b2b_b_w%0d: got v=%b d=%h want v=1 d=0032", k, out_valid, out_dat);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      int idx;
      clr_pulse();
      out_ready = 1'b0;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 8; i++) fr[i] = 14'(i * 100 + 3);
         send_frame(1'b1);
      end
      exp_w[0] = 16'hC000;
      for (int i = 0; i < 8; i++) exp_w[i + 1] = 16'(i * 100 + 3);
      idx = 0;
      for (int c = 0; c < 200 && idx < 9; c++) begin
         total++;
         if (out_valid !== 1'b1 || out_dat !== exp_w[idx]) begin
            bad++;
            $display("FAIL bp_w%0d c%0d: got v=%b d=%h want v=1 d=%h", idx, c, out_valid, out_dat, exp_w[idx]);
         end
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (out_ready) idx++;
      end
      total++;
      if (idx != 9) begin
         bad++;
         $display("FAIL bp_timeout: got %0d words want 9", idx);
      end
      out_ready = 1'b1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_idle: got v=%b want 0", out_valid);
      end
      for (int f = 0; f < 4; f++) begin
         set_fr(14'd5, 14'd5);
         send_frame(1'b1);
      end
      repeat (2) @(negedge clk);
      clr_pulse();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL clr_mid: got v=%b want 0", out_valid);
      end
      for (int f = 0; f < 4; f++) begin
         set_fr(14'd9, 14'd9);
         send_frame(1'b1);
      end
      total++;
      if (out_valid !== 1'b1 || out_dat !== 16'hC000) begin
         bad++;
         $display("FAIL clr_hdr: got v=%b d=%h want v=1 d=C000", out_valid, out_dat);
      end
      @(negedge clk);
      total++;
      if (out_dat !== 16'h0009) begin
         bad++;
         $display("FAIL clr_data: got d=%h want 0009", out_dat);
      end
   endtask

   task automatic test_ena();
      logic [13:0] c0 [6];
      logic        en [6];
      c0[0] = 14'd100;  en[0] = 1'b1;
      c0[1] = 14'd5000; en[1] = 1'b0;
      c0[2] = 14'd5000; en[2] = 1'b0;
      c0[3] = 14'd200;  en[3] = 1'b1;
      c0[4] = 14'd300;  en[4] = 1'b1;
      c0[5] = 14'd400;  en[5] = 1'b1;
      clr_pulse();
      out_ready = 1'b1;
      for (int f = 0; f < 6; f++) begin
         set_fr(c0[f], en[f] ? 14'd1234 : 14'd0);
         send_frame(en[f]);
         if (f == 4) begin
            total++;
            if (out_valid !== 1'b0) begin
               bad++;
               $display("FAIL ena_early: got v=%b want 0", out_valid);
            end
         end
      end
      total++;
      if (out_valid !== 1'b1 || out_dat !== 16'hC000) begin
         bad++;
         $display("FAIL ena_hdr: got v=%b d=%h want v=1 d=C000", out_valid, out_dat);
      end
      @(negedge clk);
      total++;
      if (out_dat !== 16'h00FA) begin
         bad++;
         $display("FAIL ena_ch0: got d=%h want 00FA", out_dat);
      end
      @(negedge clk);
      total++;
      if (out_dat !== 16'h04D2) begin
         bad++;
         $display("FAIL ena_ch1: got d=%h want 04D2", out_dat);
      end
   endtask

   task automatic test_rst_mid();
      clr_pulse();
      out_ready = 1'b0;
      for (int f = 0; f < 8; f++) begin
         set_fr(14'd11, 14'd11);
         send_frame(1'b1);
      end
      for (int f = 0; f < 2; f++) begin
         set_fr(14'd999, 14'd999);
         send_frame(1'b1);
      end
      total++;
      if (ovr !== 1'b1 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_pre: got ovr=%b v=%b want 1 1", ovr, out_valid);
      end
      rst = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_dat !== 16'h0000 || ovr !== 1'b0) begin
         bad++;
         $display("FAIL rst_async: got v=%b d=%h ovr=%b want 0 0000 0", out_valid, out_dat, ovr);
      end
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_after: got v=%b want 0", out_valid);
      end
      for (int f = 0; f < 4; f++) begin
         set_fr(14'd8, 14'd8);
         send_frame(1'b1);
      end
      total++;
      if (out_valid !== 1'b1 || out_dat !== 16'hC000) begin
         bad++;
         $display("FAIL rst_hdr: got v=%b d=%h want v=1 d=C000", out_valid, out_dat);
      end
      @(negedge clk);
      total++;
      if (out_dat !== 16'h0008) begin
         bad++;
         $display("FAIL rst_data: got d=%h want 0008", out_dat);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_trunc();
      test_overrun();
      test_back_to_back();
      test_backpressure();
      test_ena();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
